// File: rtl/mux_arbiter_reg.sv
// Registered CHANNELS:1 selector feeding a one-entry valid/ready output register.
// Fixed-select (mode=0) or round-robin among valid channels (mode=1).
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | output register holds nothing, out_valid=0
// FULL  | output register holds data, out_valid=1
module mux_arbiter_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_value,
    output logic [SEL_W-1:0]          out_channel,
    output logic                      out_valid,
    input  logic                      out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] ptr_nxt;
    logic [SEL_W-1:0] rr_idx;
    logic [SEL_W-1:0] rr_grant;
    logic             rr_found;
    logic [SEL_W-1:0] grant;
    logic             grant_valid;
    logic             fx_valid;
    logic             load_en;
    logic             take;
    logic [WIDTH-1:0] ch_data [CHANNELS];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
        assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end

    // First valid channel at or after ptr, wrapping around.
    always_comb begin
        rr_idx   = '0;
        rr_grant = '0;
        rr_found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            rr_idx = SEL_W'((int'(ptr) + k) % CHANNELS);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    // Out-of-range sel (non-power-of-2 CHANNELS) yields no grant.
    assign fx_valid    = (int'(sel) < CHANNELS) && in_valid[sel];
    assign grant       = mode ? rr_grant : sel;
    assign grant_valid = mode ? rr_found : fx_valid;

    assign out_valid = (state == FULL);
    assign load_en   = !out_valid || out_ready;
    assign take      = reset_n && load_en && grant_valid;
    assign in_ready  = take ? (CHANNELS'(1) << grant) : '0;
    assign ptr_nxt   = SEL_W'((int'(grant) + 1) % CHANNELS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (take) begin
            state_nxt = FULL;
        end else if (state == FULL && out_ready) begin
            state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_value   <= '0;
            out_channel <= '0;
            ptr         <= '0;
        end else if (take) begin
            out_value   <= ch_data[grant];
            out_channel <= grant;
            if (mode) begin
                ptr <= ptr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mux_arbiter_reg.sv
// Scoreboard bench for mux_arbiter_reg: a driver predicts each transfer from a
// behavioural model and queues it; a monitor compares what the DUT presents.
module tb_mux_arbiter_reg;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SW = 2;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [CH*W-1:0]   in_data;
    logic [CH-1:0]     in_valid;
    logic [CH-1:0]     in_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [W-1:0]      out_value;
    logic [SW-1:0]     out_channel;
    logic              out_valid;
    logic              out_ready;

    mux_arbiter_reg #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mode        (mode),
        .sel         (sel),
        .out_value   (out_value),
        .out_channel (out_channel),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  v;
        logic [SW-1:0] ch;
    } ent_t;

    ent_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: does the output register hold data, and where RR resumes.
    bit   m_full = 1'b0;
    int   m_ptr  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Evaluate the model for the inputs applied this cycle, then commit.
    task automatic model_eval();
        int          g;
        bit          gv;
        bit          xfer;
        logic [CH-1:0] exp_ready;
        ent_t        e;
        g  = 0;
        gv = 1'b0;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        if (!reset_n) begin
            check("in_ready_rst", {28'd0, in_ready}, 32'd0);
            sb.delete();
            m_full = 1'b0;
            m_ptr  = 0;
            return;
        end
        if (mode == 1'b0) begin
            g  = int'(sel);
            gv = (g < CH) && in_valid[g];
        end else begin
            for (int c = m_ptr; c < CH; c++)
                if (!gv && in_valid[c]) begin g = c; gv = 1'b1; end
            for (int c = 0; c < m_ptr; c++)
                if (!gv && in_valid[c]) begin g = c; gv = 1'b1; end
        end
        xfer      = gv && (!m_full || out_ready);
        exp_ready = xfer ? CH'(1 << g) : '0;
        check("in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
        if (xfer) begin
            e.v  = W'((in_data >> (g * W)) & 32'hFF);
            e.ch = SW'(g);
            sb.push_back(e);
            if (mode) m_ptr = (g + 1) % CH;
        end
        m_full = xfer || (m_full && !out_ready);
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    // Monitor: whatever the register presents must match the oldest queued entry.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                check("out_value", {24'd0, out_value}, {24'd0, sb[0].v});
                check("out_channel", {30'd0, out_channel}, {30'd0, sb[0].ch});
                if (out_ready === 1'b1) void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset_n   = 1'b0;
        in_data   = 32'h37E4E6EE;
        in_valid  = 4'hF;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset held two cycles with all channels valid
        step();
        step();
        check("rst_value", {24'd0, out_value}, 32'd0);
        check("rst_channel", {30'd0, out_channel}, 32'd0);
        reset_n = 1'b1;

        // Fixed mux, sel 0..3
        for (int s = 0; s < CH; s++) begin
            sel = SW'(s);
            step();
        end

        // Reset while FULL
        out_ready = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        check("rst_full_value", {24'd0, out_value}, 32'd0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'h0;
        step();

        // Round-robin, all valid, 8 cycles
        mode     = 1'b1;
        in_valid = 4'hF;
        for (int i = 0; i < 8; i++) step();

        // Sparse round-robin, then single channel 2
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) step();
        in_valid = 4'b0100;
        step();
        in_valid = 4'hF;
        step();

        // Backpressure around channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        step();
        out_ready = 1'b0;
        in_valid  = 4'hF;
        for (int i = 0; i < 3; i++) step();
        out_ready = 1'b1;
        sel       = 2'd3;
        step();
        in_valid = 4'h0;
        step();

        // Invalid select then recovery
        sel      = 2'd1;
        in_valid = 4'b1101;
        step();
        step();
        in_valid = 4'b1111;
        step();
        in_valid = 4'h0;
        step();

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            in_data   = $urandom;
            in_valid  = CH'($urandom);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            reset_n   = ($urandom_range(0, 150) != 0);
            step();
        end

        // Drain
        reset_n   = 1'b1;
        in_valid  = 4'h0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_arbiter_reg.md
Name: mux_arbiter_reg

Overview:
- Parametrised, registered successor to the fixed 8-bit 2:1/4:1 combinational muxes.
- Selects one of CHANNELS input channels of WIDTH bits and captures it into a one-entry output register with a valid/ready handshake.
- Two modes: fixed-select (plain mux behaviour via sel) and round-robin arbitration among valid channels.
- Sits between multiple bus sources (RAM, ROM, IO, ALU result) and a single consumer in the emulator datapath.

Parameters:
- WIDTH, 8, data width of each channel and of the output.
- CHANNELS, 4, number of input channels; must be >= 2.
- SEL_W, $clog2(CHANNELS), width of sel and out_channel.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel accept strobe; at most one bit is set (one-hot or zero).
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- out_value  output  WIDTH  registered selected data.
- out_channel  output  SEL_W  index of the channel that produced out_value.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts out_value.

Behaviour:
Reset (reset_n=0 sampled at clk):
- out_valid=0, out_value=0, out_channel=0, round-robin pointer ptr=0.
- in_ready is all-zero while reset_n=0.
- Reset mid-transfer drops the held entry; no in_ready is asserted in the reset cycle.

State: EMPTY (out_valid=0) and FULL (out_valid=1). State changes only on the clk edge.

Load enable and acceptance:
- load_en = !out_valid || out_ready (combinational).
- Grant is combinational from in_valid, mode, sel and ptr.
- in_ready[g] = load_en && grant_valid, where g is the granted channel.
- A transfer on channel i occurs when in_valid[i] && in_ready[i].

Grant rules:
- mode=0: g = sel, grant_valid = in_valid[sel].
  - If sel >= CHANNELS (non-power-of-2 CHANNELS), there is no grant.
- mode=1: g = first i with in_valid[i]=1, scanning ptr, ptr+1, …, wrapping mod CHANNELS; grant_valid = |in_valid.

On a transfer (edge):
- out_value <= channel g data, out_channel <= g, out_valid <= 1.
- If mode=1, ptr <= (g+1) mod CHANNELS.
- ptr does not change in mode=0 or when there is no transfer.

Pop without load: out_valid && out_ready with no transfer -> out_valid <= 0; out_value and out_channel hold their last values.

Simultaneous pop and load: the register is refilled in the same edge, sustaining 1 transfer/cycle.

Latency: 1 cycle from accepted input to out_valid.

Stall: while FULL and out_ready=0, out_value, out_channel and out_valid are stable, and in_ready is all-zero.

Mode or sel changes:
- These take effect on the next grant evaluation only; a held entry is never altered.
- Switching to mode=1 resumes from the current ptr.

Round-robin fairness: with all channels continuously valid and out_ready=1, channels are granted 0,1,…,CHANNELS-1,0,… in order.

Test Plan (WIDTH=8, CHANNELS=4):
1. Fixed mux: in_data = {D=8'h37, C=8'hE4, B=8'hE6, A=8'hEE}, in_valid=4'hF, mode=0, out_ready=1; step sel 0..3 -> out_value EE, E6, E4, 37 each one cycle after its sel is applied; out_channel = sel; in_ready = 1<<sel.
2. Reset: hold reset_n=0 for 2 cycles with in_valid=4'hF -> out_valid=0, out_value=0, out_channel=0, in_ready=0; assert reset_n=0 while FULL -> out_valid=0 on the next edge.
3. Round-robin: mode=1, in_valid=4'hF, out_ready=1 for 8 cycles -> out_channel sequence 0,1,2,3,0,1,2,3, with 1 transfer/cycle.
4. Sparse round-robin: mode=1, in_valid=4'b1010 -> grants alternate 1,3,1,3; then in_valid=4'b0100 -> grant 2, after which ptr=3.
5. Backpressure: load channel 2 (8'hE4), then hold out_ready=0 for 3 cycles with in_valid=4'hF -> out_value=E4 stable, in_ready=0; set out_ready=1 -> pop and reload occur in the same cycle.
6. Invalid select: mode=0, sel=1, in_valid=4'b1101 -> no transfer, out_valid stays 0, in_ready=0; set in_valid[1]=1 -> captured next edge.
